// File: rtl/seq_divider_16bit_pkg.sv
// Shared types and constants for the 16-bit sequential divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_divider_16bit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ITERATIONS = 16;
    localparam int CNT_W      = 4;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

endpackage

// File: rtl/seq_divider_16bit_sub_17bit.sv
// 17-bit trial subtractor: diff = a - b computed as a + ~b + 1.
// Latency: combinational.
// Backpressure: n/a.
module sub_17bit (
    input  logic [16:0] a,
    input  logic [16:0] b,
    output logic [16:0] diff,
    output logic        borrow_out
);

    logic [17:0] sum;

    // Carry out of the two's-complement add means no borrow.
    assign sum        = {1'b0, a} + {1'b0, ~b} + 18'd1;
    assign diff       = sum[16:0];
    assign borrow_out = ~sum[17];

endmodule

// File: rtl/seq_divider_16bit.sv
// Unsigned 16-bit restoring divider, one quotient bit per cycle, MSB first.
// Latency: done 17 cycles after accepted start (1 cycle for divisor 0).
// Backpressure: none; start is ignored while busy.
import seq_divider_16bit_pkg::*;

module seq_divider_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   dvd_sr;
    logic [WIDTH-1:0]   dvs_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH:0]     trial_a;
    logic [WIDTH:0]     trial_b;
    logic [WIDTH:0]     trial_diff;
    logic               borrow;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic               accept;
    logic               last;

    assign accept = (state == IDLE) && start;
    assign last   = (cnt == LAST_ITER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // dvd_sr shifts dividend bits out of the top while quotient bits enter at the bottom.
    assign trial_a = {rem_r, dvd_sr[WIDTH-1]};
    assign trial_b = {1'b0, dvs_r};

    sub_17bit u_sub (
        .a          (trial_a),
        .b          (trial_b),
        .diff       (trial_diff),
        .borrow_out (borrow)
    );

    // On borrow the trial operand is below the divisor, so it fits in WIDTH bits.
    assign rem_nxt = borrow ? trial_a[WIDTH-1:0] : trial_diff[WIDTH-1:0];
    assign quo_nxt = {dvd_sr[WIDTH-2:0], ~borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            dvd_sr      <= '0;
            dvs_r       <= '0;
            rem_r       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            dvd_sr <= dividend;
            dvs_r  <= divisor;
            rem_r  <= '0;
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                div_by_zero <= 1'b0;
            end
        end else if (state == CALC) begin
            dvd_sr <= quo_nxt;
            rem_r  <= rem_nxt;
            if (last) begin
                quotient  <= quo_nxt;
                remainder <= rem_nxt;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider_16bit.sv
// Randomized self-checking bench for seq_divider_16bit against a plain-arithmetic model.
module tb_seq_divider_16bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int n_chk  = 0;
    int n_pass = 0;

    seq_divider_16bit #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one division; inj_cyc > 0 pulses a stray start (with new operands) in that CALC cycle.
    task automatic run_div(input logic [15:0] a, input logic [15:0] b, input int inj_cyc, input string tag);
        int          lat;
        logic [15:0] exp_q;
        logic [15:0] exp_r;
        int          exp_lat;
        exp_q   = (b == 16'd0) ? 16'hFFFF : a / b;
        exp_r   = (b == 16'd0) ? a : a % b;
        exp_lat = (b == 16'd0) ? 1 : 17;
        @(negedge clk);
        check({tag, " idle_before"}, {31'd0, busy}, 32'd0);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        lat      = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start    = 1'b0;
            dividend = 16'($urandom);
            divisor  = 16'($urandom);
            if (c == inj_cyc) start = 1'b1;
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        check({tag, " latency"},   lat, exp_lat);
        check({tag, " quotient"},  {16'd0, quotient},  {16'd0, exp_q});
        check({tag, " remainder"}, {16'd0, remainder}, {16'd0, exp_r});
        check({tag, " dbz"},       {31'd0, div_by_zero}, {31'd0, (b == 16'd0)});
        check({tag, " busy_done"}, {31'd0, busy}, 32'd1);
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        int          sel;
        int          inj;
        int          seen_done;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 16'd0;
        #1;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst quotient", {16'd0, quotient}, 32'd0);
        check("rst remainder", {16'd0, remainder}, 32'd0);
        check("rst dbz", {31'd0, div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_div(16'd100, 16'd7, 0, "100/7");
        run_div(16'hFFFF, 16'd1, 0, "ffff/1");
        run_div(16'hFFFF, 16'hFFFF, 0, "ffff/ffff");
        run_div(16'd5, 16'd0, 0, "5/0");
        run_div(16'd3, 16'd10, 0, "3/10");
        run_div(16'd1000, 16'd33, 0, "b2b 1000/33");
        run_div(16'd200, 16'd9, 6, "200/9 stray");

        // Results must hold while idle with inputs wandering.
        repeat (4) begin
            @(negedge clk);
            dividend = 16'($urandom);
            divisor  = 16'($urandom);
        end
        check("hold quotient", {16'd0, quotient}, 32'd22);
        check("hold remainder", {16'd0, remainder}, 32'd2);
        check("hold busy", {31'd0, busy}, 32'd0);

        // Abort mid-calculation with reset.
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'd1234;
        divisor  = 16'd7;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort quotient", {16'd0, quotient}, 32'd0);
        check("abort remainder", {16'd0, remainder}, 32'd0);
        check("abort dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        seen_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        check("abort no_done", seen_done, 0);
        run_div(16'd9, 16'd4, 0, "9/4 after rst");

        // Random operations, mixing zero, small and full-range divisors.
        for (int i = 0; i < 40; i++) begin
            a   = 16'($urandom);
            sel = $urandom_range(0, 3);
            if (sel == 0)      b = 16'd0;
            else if (sel == 1) b = 16'($urandom_range(1, 15));
            else               b = 16'($urandom);
            if (sel == 3 && b == 16'd0) b = 16'd1;
            inj = (b != 16'd0 && $urandom_range(0, 1) == 1) ? $urandom_range(2, 15) : 0;
            run_div(a, b, inj, $sformatf("rand%0d", i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
